// File: rtl/timekeeper_ctrl.sv
// Sequencing controller for the digital-clock counter chain: 1 Hz prescaler,
// cascaded count enables and the RUN / SET_HR / SET_MIN time-set FSM.
module timekeeper_ctrl #(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       sec_tc,
  input  logic       min_tc,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       dir,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_DIV / 2);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HR   = 2'b01,
    SET_MIN  = 2'b10,
    MODE_BAD = 2'b11
  } mode_t;

  mode_t            mode_reg;
  mode_t            mode_next;
  logic [PRE_W-1:0] presc_reg;
  logic [PRE_W-1:0] presc_next;
  logic             sec_en_reg;
  logic             min_en_reg;
  logic             hr_en_reg;
  logic             dir_reg;
  logic             sec_clr_reg;
  logic             blink_reg;

  logic tick;
  logic in_set;
  logic adj_valid;
  logic exit_min;

  assign tick      = (presc_reg == PRE_LAST);
  assign in_set    = (mode_reg == SET_HR) || (mode_reg == SET_MIN);
  // A mode press overrides any adjust; up and down together cancel out.
  assign adj_valid = in_set && !btn_mode && (btn_up ^ btn_down);
  assign exit_min  = (mode_reg == SET_MIN) && btn_mode;

  always_comb begin
    mode_next = mode_reg;
    case (mode_reg)
      RUN:     if (btn_mode) mode_next = SET_HR;
      SET_HR:  if (btn_mode) mode_next = SET_MIN;
      SET_MIN: if (btn_mode) mode_next = RUN;
      default: mode_next = RUN;
    endcase
  end

  // Leaving SET_MIN restarts the second so the first RUN tick is a full period away.
  assign presc_next = (exit_min || tick) ? '0 : presc_reg + PRE_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_reg    <= RUN;
      presc_reg   <= '0;
      sec_en_reg  <= 1'b0;
      min_en_reg  <= 1'b0;
      hr_en_reg   <= 1'b0;
      dir_reg     <= 1'b1;
      sec_clr_reg <= 1'b0;
      blink_reg   <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      presc_reg   <= presc_next;
      sec_clr_reg <= exit_min;
      // Built from next-state values so blink lines up with the visible mode and prescaler.
      blink_reg   <= (mode_next != RUN) && (presc_next < PRE_HALF);

      if (mode_reg == RUN) begin
        sec_en_reg <= tick;
        min_en_reg <= tick & sec_tc;
        hr_en_reg  <= tick & sec_tc & min_tc;
      end else begin
        sec_en_reg <= 1'b0;
        min_en_reg <= adj_valid && (mode_reg == SET_MIN);
        hr_en_reg  <= adj_valid && (mode_reg == SET_HR);
      end

      if (mode_next == RUN)
        dir_reg <= 1'b1;
      else if (adj_valid)
        dir_reg <= btn_up;
    end
  end

  assign sec_en  = sec_en_reg;
  assign min_en  = min_en_reg;
  assign hr_en   = hr_en_reg;
  assign dir     = dir_reg;
  assign sec_clr = sec_clr_reg;
  assign mode    = mode_reg;
  assign blink   = blink_reg;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Directed bench for timekeeper_ctrl with CLK_DIV=4; inputs driven and outputs
// sampled on the falling edge, cycle 0 being the first cycle after the last reset edge.
module tb_timekeeper_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       sec_tc;
  logic       min_tc;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       dir;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blink;

  int n_checks;
  int n_pass;
  int cyc_n;

  timekeeper_ctrl #(.CLK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .sec_tc   (sec_tc),
    .min_tc   (min_tc),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hr_en    (hr_en),
    .dir      (dir),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .blink    (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc_n, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc_n    = 0;
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    sec_tc   = 1'b0;
    min_tc   = 1'b0;

    // Reset state, then free-running seconds
    repeat (3) @(negedge clk);
    cyc_n = 0;
    check("rst_sec_en", 32'(sec_en), 32'd0);
    check("rst_min_en", 32'(min_en), 32'd0);
    check("rst_hr_en", 32'(hr_en), 32'd0);
    check("rst_sec_clr", 32'(sec_clr), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_dir", 32'(dir), 32'd1);
    check("rst_blink", 32'(blink), 32'd0);
    $display("txn reset: defaults sampled");
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("run_sec_en", 32'(sec_en), 32'(k % 4 == 0));
      check("run_min_en", 32'(min_en), 32'd0);
      check("run_hr_en", 32'(hr_en), 32'd0);
    end
    check("run_mode", 32'(mode), 32'd0);
    check("run_dir", 32'(dir), 32'd1);
    $display("txn run: sec_en every 4 cycles");

    // Cascade: seconds at terminal, then minutes at terminal too
    sec_tc = 1'b1;
    for (int k = 13; k <= 16; k++) begin
      step();
      check("casc_sec_en", 32'(sec_en), 32'(k % 4 == 0));
      check("casc_min_en", 32'(min_en), 32'(k % 4 == 0));
      check("casc_hr_en", 32'(hr_en), 32'd0);
    end
    min_tc = 1'b1;
    for (int k = 17; k <= 20; k++) begin
      step();
      check("casc2_sec_en", 32'(sec_en), 32'(k % 4 == 0));
      check("casc2_min_en", 32'(min_en), 32'(k % 4 == 0));
      check("casc2_hr_en", 32'(hr_en), 32'(k % 4 == 0));
    end
    sec_tc = 1'b0;
    min_tc = 1'b0;
    $display("txn cascade: min_en and hr_en follow terminal counts");

    // Enter SET_HR at cycle 20 (prescaler 0)
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("sethr_mode", 32'(mode), 32'd1);
    check("sethr_blink", 32'(blink), 32'(cyc_n % 4 < 2));
    for (int k = 22; k <= 40; k++) begin
      step();
      check("sethr_no_sec_en", 32'(sec_en), 32'd0);
      check("sethr_blink", 32'(blink), 32'(k % 4 < 2));
    end
    $display("txn mode: entered SET_HR, blink 1,1,0,0");

    btn_up = 1'b1;
    step();
    btn_up = 1'b0;
    check("hr_up_en", 32'(hr_en), 32'd1);
    check("hr_up_dir", 32'(dir), 32'd1);
    check("hr_up_min_en", 32'(min_en), 32'd0);
    check("hr_up_sec_en", 32'(sec_en), 32'd0);
    step();
    check("hr_up_width", 32'(hr_en), 32'd0);
    $display("txn btn_up: hr_en pulse, dir up");
    btn_down = 1'b1;
    step();
    btn_down = 1'b0;
    check("hr_dn_en", 32'(hr_en), 32'd1);
    check("hr_dn_dir", 32'(dir), 32'd0);
    step();
    check("hr_dn_width", 32'(hr_en), 32'd0);
    check("hr_dn_dir_hold", 32'(dir), 32'd0);
    $display("txn btn_down: hr_en pulse, dir down");

    // SET_MIN with conflicting buttons
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("setmin_mode", 32'(mode), 32'd2);
    check("setmin_dir_hold", 32'(dir), 32'd0);
    btn_up   = 1'b1;
    btn_down = 1'b1;
    step();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    check("both_min_en", 32'(min_en), 32'd0);
    check("both_hr_en", 32'(hr_en), 32'd0);
    check("both_sec_en", 32'(sec_en), 32'd0);
    $display("txn up+down: ignored");
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    step();
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    check("exit_mode", 32'(mode), 32'd0);
    check("exit_min_en", 32'(min_en), 32'd0);
    check("exit_sec_clr", 32'(sec_clr), 32'd1);
    check("exit_dir", 32'(dir), 32'd1);
    check("exit_blink", 32'(blink), 32'd0);
    for (int k = 48; k <= 51; k++) begin
      step();
      check("exit_sec_clr_width", 32'(sec_clr), 32'd0);
      check("exit_sec_en", 32'(sec_en), 32'(k == 51));
    end
    $display("txn mode+up: back to RUN, sec_clr, prescaler reloaded");

    // Reset in SET_MIN coinciding with btn_up
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("r_sethr_mode", 32'(mode), 32'd1);
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    check("r_setmin_mode", 32'(mode), 32'd2);
    step();
    check("r_idle_min_en", 32'(min_en), 32'd0);
    btn_down = 1'b1;
    step();
    btn_down = 1'b0;
    check("r_min_dn_en", 32'(min_en), 32'd1);
    check("r_min_dn_dir", 32'(dir), 32'd0);
    btn_up = 1'b1;
    reset  = 1'b0;
    step();
    btn_up = 1'b0;
    reset  = 1'b1;
    check("r_mode", 32'(mode), 32'd0);
    check("r_sec_en", 32'(sec_en), 32'd0);
    check("r_min_en", 32'(min_en), 32'd0);
    check("r_hr_en", 32'(hr_en), 32'd0);
    check("r_sec_clr", 32'(sec_clr), 32'd0);
    check("r_blink", 32'(blink), 32'd0);
    check("r_dir", 32'(dir), 32'd1);
    for (int k = 57; k <= 60; k++) begin
      step();
      check("r_after_min_en", 32'(min_en), 32'd0);
      check("r_after_sec_en", 32'(sec_en), 32'(k == 60));
    end
    $display("txn reset mid-adjust: RUN, prescaler restarted");

    // Fifty seconds with varying terminal-count flags in the tick cycle
    sec_tc = 1'b1;
    min_tc = 1'b1;
    for (int i = 0; i < 50; i++) begin
      logic s;
      logic m;
      repeat (3) begin
        step();
        check("sweep_idle_min_en", 32'(min_en), 32'd0);
        check("sweep_idle_hr_en", 32'(hr_en), 32'd0);
      end
      s = (i % 3 != 0);
      m = (i % 2 == 1);
      sec_tc = s;
      min_tc = m;
      step();
      check("sweep_sec_en", 32'(sec_en), 32'd1);
      check("sweep_min_en", 32'(min_en), 32'(s));
      check("sweep_hr_en", 32'(hr_en), 32'(s & m));
      sec_tc = 1'b1;
      min_tc = 1'b1;
      $display("txn sweep %0d: sec_tc=%0d min_tc=%0d min_en=%0d hr_en=%0d", i, s, m, min_en, hr_en);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
